// File: rtl/sdram_arbiter_if.sv
// Signal bundle between the two requesters, sdram_arbiter and the SDRAM
// controller command port.
//   slave  : the arbiter's view (requests in, acks/rdata/command out)
//   master : the environment's view (requesters plus controller)
interface sdram_arbiter_if;
    // Requester side
    logic        p0_req;
    logic        p1_req;
    logic        p0_write;
    logic        p1_write;
    logic [24:0] p0_addr;
    logic [24:0] p1_addr;
    logic [31:0] p0_wdata;
    logic [31:0] p1_wdata;
    logic [1:0]  p0_dwidth;
    logic [1:0]  p1_dwidth;
    logic        p0_ack;
    logic        p1_ack;
    logic [31:0] p0_rdata;
    logic [31:0] p1_rdata;

    // Controller side
    logic        sdram_enable;
    logic        sdram_write;
    logic [24:0] sdram_addr;
    logic [31:0] sdram_wdata;
    logic [1:0]  sdram_dwidth;
    logic [31:0] sdram_rdata;
    logic        sdram_ready;

    // Status
    logic        init_done;
    logic        busy;
    logic        grant_id;

    modport slave (
        input  p0_req, p1_req, p0_write, p1_write, p0_addr, p1_addr,
               p0_wdata, p1_wdata, p0_dwidth, p1_dwidth,
               sdram_rdata, sdram_ready,
        output p0_ack, p1_ack, p0_rdata, p1_rdata,
               sdram_enable, sdram_write, sdram_addr, sdram_wdata, sdram_dwidth,
               init_done, busy, grant_id
    );

    modport master (
        output p0_req, p1_req, p0_write, p1_write, p0_addr, p1_addr,
               p0_wdata, p1_wdata, p0_dwidth, p1_dwidth,
               sdram_rdata, sdram_ready,
        input  p0_ack, p1_ack, p0_rdata, p1_rdata,
               sdram_enable, sdram_write, sdram_addr, sdram_wdata, sdram_dwidth,
               init_done, busy, grant_id
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller command port between the CPU
// data path (port 0) and a DMA / framebuffer master (port 1).
// Flow: INIT (wait for first ready) -> IDLE -> ISSUE (one-cycle enable)
//       -> BUSY (guarded wait for ready) -> DONE (ack pulse) -> IDLE.
// Optional feature macro: SDRAM_ARB_RR_EN selects round-robin tie breaking;
// when undefined, port 0 has fixed priority on ties.
module sdram_arbiter #(
    parameter int READY_GUARD = 1   // BUSY cycles with ready ignored, 1..7
) (
    input  logic           clk,
    input  logic           rst,
    sdram_arbiter_if.slave bus
);
    localparam int         ADDR_W     = 25;
    localparam int         DATA_W     = 32;
    localparam logic [2:0] GUARD_LOAD = 3'(READY_GUARD);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_BUSY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          guard_q, guard_d;
    logic                init_done_q, init_done_d;
    logic                grant_q, grant_d;
    logic                cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [1:0]          cmd_dwidth_q, cmd_dwidth_d;
    logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
    logic                any_req;
    logic                winner;

`ifdef SDRAM_ARB_RR_EN
    logic                last_q, last_d;
`endif

    // Decide which port would win if IDLE sampled the requests this cycle.
    always_comb begin
        any_req = bus.p0_req | bus.p1_req;
`ifdef SDRAM_ARB_RR_EN
        // On a tie the port that did not get the previous grant goes first.
        if (bus.p0_req && bus.p1_req) begin
            winner = ~last_q;
        end else begin
            winner = bus.p1_req;
        end
`else
        // Port 1 only wins when port 0 is not asking.
        winner = bus.p1_req & ~bus.p0_req;
`endif
    end

    // Next-state, command capture and read-data capture for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        guard_d      = guard_q;
        init_done_d  = init_done_q;
        grant_d      = grant_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_dwidth_d = cmd_dwidth_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
`ifdef SDRAM_ARB_RR_EN
        last_d       = last_q;
`endif

        case (state_q)
            ST_INIT: begin
                // Requests are ignored until the controller first reports ready.
                if (bus.sdram_ready) begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (any_req) begin
                    grant_d = winner;
`ifdef SDRAM_ARB_RR_EN
                    last_d  = winner;
`endif
                    if (winner) begin
                        cmd_write_d  = bus.p1_write;
                        cmd_addr_d   = bus.p1_addr;
                        cmd_wdata_d  = bus.p1_wdata;
                        cmd_dwidth_d = bus.p1_dwidth;
                    end else begin
                        cmd_write_d  = bus.p0_write;
                        cmd_addr_d   = bus.p0_addr;
                        cmd_wdata_d  = bus.p0_wdata;
                        cmd_dwidth_d = bus.p0_dwidth;
                    end
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // The controller may still show the previous ready level for a
                // few cycles after the strobe; the guard hides that window.
                guard_d = GUARD_LOAD;
                state_d = ST_BUSY;
            end

            ST_BUSY: begin
                if (guard_q != 3'd0) begin
                    guard_d = guard_q - 3'd1;
                end else if (bus.sdram_ready) begin
                    if (!cmd_write_q) begin
                        if (grant_q) begin
                            p1_rdata_d = bus.sdram_rdata;
                        end else begin
                            p0_rdata_d = bus.sdram_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Transaction state, registered command and per-port read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            guard_q      <= 3'd0;
            init_done_q  <= 1'b0;
            grant_q      <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_dwidth_q <= 2'b00;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            guard_q      <= guard_d;
            init_done_q  <= init_done_d;
            grant_q      <= grant_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_dwidth_q <= cmd_dwidth_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

`ifdef SDRAM_ARB_RR_EN
    // Last-grant pointer; starts at port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Outputs are decoded straight from registers, so they drop as soon as
    // reset is asserted.
    assign bus.sdram_enable = (state_q == ST_ISSUE);
    assign bus.sdram_write  = cmd_write_q;
    assign bus.sdram_addr   = cmd_addr_q;
    assign bus.sdram_wdata  = cmd_wdata_q;
    assign bus.sdram_dwidth = cmd_dwidth_q;
    assign bus.p0_ack       = (state_q == ST_DONE) & ~grant_q;
    assign bus.p1_ack       = (state_q == ST_DONE) &  grant_q;
    assign bus.p0_rdata     = p0_rdata_q;
    assign bus.p1_rdata     = p1_rdata_q;
    assign bus.init_done    = init_done_q;
    assign bus.grant_id     = grant_q;
    assign bus.busy         = (state_q == ST_ISSUE) || (state_q == ST_BUSY) ||
                              (state_q == ST_DONE);
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed init / table / contention / reset
// sequences on a READY_GUARD=1 instance, a latency check on a READY_GUARD=3
// instance, and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_sdram_arbiter;
    localparam int G1 = 1;
    localparam int G3 = 3;
`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_arbiter_if bus1();
    sdram_arbiter_if bus3();

    sdram_arbiter #(.READY_GUARD(G1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sdram_arbiter #(.READY_GUARD(G3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        bit          port;
        bit          wr;
        logic [24:0] addr;
        logic [31:0] wdata;
        logic [1:0]  dw;
        int          drop;     // ready held low on cycles E+1..E+drop after enable at E
        logic [31:0] ret;
        int          exp_lat;  // sample cycle to ack cycle
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
    } vec_t;

    vec_t vt[6];

    // Scratch state for the sequences
    int          start, en_cnt, ack_own, ack_oth, ack_cyc, e_cyc, rise, n, prev_en;
    logic [60:0] cmd_seen;
    logic        g[5];
    logic        exp_g[4];
    bit          found;

    // Random-phase model state
    bit          act[2];
    bit          pwr[2];
    logic [24:0] paddr[2];
    logic [31:0] pwd[2];
    logic [1:0]  pdw[2];
    logic [31:0] exp_rd[2];
    logic [31:0] ret;
    logic [1:0]  exp_acks;
    bit          in_flight, win, last;
    int          idle_from, exp_en, exp_ack, d, n_txn;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input bit req, input bit wr, input logic [24:0] a,
                              input logic [31:0] wd, input logic [1:0] w);
        if (p == 0) begin
            bus1.p0_req = req; bus1.p0_write = wr; bus1.p0_addr = a;
            bus1.p0_wdata = wd; bus1.p0_dwidth = w;
        end else begin
            bus1.p1_req = req; bus1.p1_write = wr; bus1.p1_addr = a;
            bus1.p1_wdata = wd; bus1.p1_dwidth = w;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 1'b0, 25'h0000010, 32'h11110000, 2'b10, 5, 32'hDEADBEEF, 8, 32'hDEADBEEF, 32'h0};
        vt[1] = '{1'b1, 1'b1, 25'h0000003, 32'h000000A5, 2'b00, 0, 32'hFFFFFFFF, 4, 32'hDEADBEEF, 32'h0};
        vt[2] = '{1'b1, 1'b0, 25'h1FFFFFC, 32'h22220000, 2'b10, 2, 32'hCAFEF00D, 5, 32'hDEADBEEF, 32'hCAFEF00D};
        vt[3] = '{1'b0, 1'b1, 25'h1FFFFFF, 32'h00005A5A, 2'b01, 1, 32'h00000000, 4, 32'hDEADBEEF, 32'hCAFEF00D};
        vt[4] = '{1'b0, 1'b0, 25'h0000000, 32'h33330000, 2'b01, 3, 32'h0000BEEF, 6, 32'h0000BEEF, 32'hCAFEF00D};
        vt[5] = '{1'b1, 1'b1, 25'h0ABCDEF, 32'h00000000, 2'b10, 7, 32'h77777777, 10, 32'h0000BEEF, 32'hCAFEF00D};
        if (RR) begin
            exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
        end else begin
            exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0; exp_g[3] = 1'b0;
        end

        // ---- Reset and initialisation ----
        rst = 1'b1;
        drive_port(0, 1'b0, 1'b0, '0, '0, 2'b00);
        drive_port(1, 1'b0, 1'b0, '0, '0, 2'b00);
        bus1.sdram_ready = 1'b0; bus1.sdram_rdata = '0;
        bus3.p0_req = 1'b0; bus3.p1_req = 1'b0; bus3.p0_write = 1'b0; bus3.p1_write = 1'b0;
        bus3.p0_addr = '0; bus3.p1_addr = '0; bus3.p0_wdata = '0; bus3.p1_wdata = '0;
        bus3.p0_dwidth = 2'b10; bus3.p1_dwidth = 2'b00;
        bus3.sdram_ready = 1'b1; bus3.sdram_rdata = 32'h33333333;
        tick(); tick();
        chk("reset_ctrl", 128'({bus1.sdram_enable, bus1.busy, bus1.init_done, bus1.grant_id,
                                bus1.p0_ack, bus1.p1_ack, bus1.sdram_write, bus1.sdram_dwidth}), 128'h0);
        chk("reset_data", 128'({bus1.sdram_addr, bus1.sdram_wdata, bus1.p0_rdata, bus1.p1_rdata}), 128'h0);
        drive_port(0, 1'b1, 1'b0, 25'h0000040, 32'h0, 2'b10);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("init_hold", 128'({bus1.sdram_enable, bus1.init_done, bus1.busy}), 128'h0);
        end
        bus1.sdram_ready = 1'b1; bus1.sdram_rdata = 32'h12345678;
        tick();
        chk("init_done_set", 128'({bus1.init_done, bus1.sdram_enable}), 128'b10);
        tick();
        chk("enable_after_init", 128'({bus1.sdram_enable, bus1.grant_id, bus1.sdram_addr}), 128'({2'b10, 25'h40}));
        tick(); tick();
        chk("init_txn_no_early_ack", 128'({bus1.p1_ack, bus1.p0_ack}), 128'h0);
        tick();
        chk("init_txn_ack", 128'({bus1.p1_ack, bus1.p0_ack, bus1.p0_rdata}), 128'({2'b01, 32'h12345678}));
        drive_port(0, 1'b0, 1'b0, '0, '0, 2'b00);

        // ---- Table of single-port transactions ----
        for (int i = 0; i < 6; i++) begin
            tick();
            start = cyc; en_cnt = 0; ack_own = 0; ack_oth = 0; ack_cyc = -1; e_cyc = -1;
            cmd_seen = '0;
            rise = (vt[i].drop > G1) ? vt[i].drop : G1;
            drive_port(vt[i].port, 1'b1, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].dw);
            bus1.sdram_ready = 1'b1; bus1.sdram_rdata = ~vt[i].ret;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (bus1.sdram_enable) begin
                    en_cnt++; e_cyc = cyc;
                    cmd_seen = {bus1.sdram_write, bus1.sdram_addr, bus1.sdram_wdata,
                                bus1.sdram_dwidth, bus1.grant_id};
                end
                if ((vt[i].port ? bus1.p1_ack : bus1.p0_ack) == 1'b1) begin
                    ack_own++;
                    if (ack_cyc < 0) ack_cyc = cyc;
                    drive_port(vt[i].port, 1'b0, 1'b0, '0, '0, 2'b00);
                end
                if ((vt[i].port ? bus1.p0_ack : bus1.p1_ack) == 1'b1) ack_oth++;
                bus1.sdram_ready = !(e_cyc >= 0 && cyc >= e_cyc + 1 && cyc <= e_cyc + vt[i].drop);
                bus1.sdram_rdata = (e_cyc >= 0 && cyc >= e_cyc + 1 + rise) ? vt[i].ret : ~vt[i].ret;
                if (ack_cyc >= 0 && cyc >= ack_cyc + 3) break;
            end
            chk($sformatf("vec%0d_enable_count", i), 128'(en_cnt), 128'(1));
            chk($sformatf("vec%0d_cmd", i), 128'(cmd_seen),
                128'({vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].dw, vt[i].port}));
            chk($sformatf("vec%0d_acks", i), 128'({ack_own[7:0], ack_oth[7:0]}), 128'h0100);
            chk($sformatf("vec%0d_latency", i), 128'(ack_cyc - start), 128'(vt[i].exp_lat));
            chk($sformatf("vec%0d_rdata", i), 128'({bus1.p0_rdata, bus1.p1_rdata}),
                128'({vt[i].exp_rd0, vt[i].exp_rd1}));
        end

        // ---- Both ports requesting continuously ----
        tick();
        bus1.sdram_ready = 1'b1; bus1.sdram_rdata = 32'h0BAD0BAD;
        drive_port(0, 1'b1, 1'b0, 25'h0000100, 32'h0, 2'b10);
        drive_port(1, 1'b1, 1'b0, 25'h0000200, 32'h0, 2'b10);
        n = 0; prev_en = -1;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (bus1.sdram_enable) begin
                if (n < 5) g[n] = bus1.grant_id;
                if (n > 0) chk("b2b_gap", 128'(cyc - prev_en), 128'(5));
                prev_en = cyc; n++;
            end
            if ((bus1.p0_ack || bus1.p1_ack) && n == 4) bus1.p0_req = 1'b0;
            if (bus1.p1_ack && n == 5) begin
                bus1.p1_req = 1'b0;
                break;
            end
        end
        chk("contend_enable_count", 128'(n), 128'(5));
        for (int i = 0; i < 4; i++) chk($sformatf("contend_grant%0d", i), 128'(g[i]), 128'(exp_g[i]));
        chk("contend_grant_after_drop", 128'(g[4]), 128'(1));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("idle_after_contend", 128'({bus1.sdram_enable, bus1.p0_ack, bus1.p1_ack}), 128'h0);
        end

        // ---- Asynchronous reset while BUSY ----
        bus1.sdram_ready = 1'b0;
        drive_port(0, 1'b1, 1'b0, 25'h0000044, 32'h0, 2'b10);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus1.sdram_enable) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_enable_seen", 128'(found), 128'(1));
        tick(); tick();
        chk("rst_busy_before", 128'(bus1.busy), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", 128'({bus1.sdram_enable, bus1.busy, bus1.init_done, bus1.grant_id,
                                  bus1.p0_ack, bus1.p1_ack, bus1.sdram_write, bus1.sdram_dwidth}), 128'h0);
        chk("rst_mid_data", 128'({bus1.sdram_addr, bus1.sdram_wdata, bus1.p0_rdata, bus1.p1_rdata}), 128'h0);
        drive_port(0, 1'b0, 1'b0, '0, '0, 2'b00);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst_reinit_wait", 128'({bus1.p0_ack, bus1.p1_ack, bus1.sdram_enable,
                                        bus1.busy, bus1.init_done}), 128'h0);
        end
        bus1.sdram_ready = 1'b1;
        tick();
        chk("rst_reinit_done", 128'({bus1.init_done, bus1.sdram_enable, bus1.busy,
                                    bus1.p0_ack, bus1.p1_ack}), 128'b10000);

        // ---- READY_GUARD = 3 latency, ready high throughout ----
        tick();
        start = cyc; ack_own = 0; ack_cyc = -1;
        bus3.p0_req = 1'b1; bus3.p0_addr = 25'h0000080;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus3.p0_ack) begin
                ack_own++;
                if (ack_cyc < 0) ack_cyc = cyc;
                bus3.p0_req = 1'b0;
            end
        end
        chk("guard3_latency", 128'(ack_cyc - start), 128'(6));
        chk("guard3_ack_count", 128'(ack_own), 128'(1));
        chk("guard3_rdata", 128'(bus3.p0_rdata), 128'h33333333);

        // ---- Randomized traffic against a transaction-level model ----
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; pwr[p] = 1'b0; paddr[p] = '0; pwd[p] = '0; pdw[p] = 2'b00;
            exp_rd[p] = '0;
        end
        in_flight = 1'b0; win = 1'b0; last = 1'b1;
        idle_from = cyc; exp_en = -1; exp_ack = -1; e_cyc = -1; d = 0; ret = '0; n_txn = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            chk("rnd_enable", 128'(bus1.sdram_enable), 128'(cyc == exp_en));
            if (cyc == exp_en) begin
                chk("rnd_cmd", 128'({bus1.sdram_write, bus1.sdram_addr, bus1.sdram_wdata,
                                     bus1.sdram_dwidth, bus1.grant_id}),
                    128'({pwr[win], paddr[win], pwd[win], pdw[win], win}));
                e_cyc = cyc; d = $urandom_range(0, 3); ret = $urandom;
                exp_ack = e_cyc + 2 + G1 + d;
            end
            exp_acks = (cyc == exp_ack) ? (win ? 2'b10 : 2'b01) : 2'b00;
            chk("rnd_ack", 128'({bus1.p1_ack, bus1.p0_ack}), 128'(exp_acks));
            if (cyc == exp_ack) begin
                if (!pwr[win]) exp_rd[win] = ret;
                chk("rnd_rdata", 128'({bus1.p0_rdata, bus1.p1_rdata}), 128'({exp_rd[0], exp_rd[1]}));
                in_flight = 1'b0; idle_from = cyc + 1; act[win] = 1'b0; n_txn++;
            end
            // Requesters hold each command until its ack, sometimes reissuing at once.
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && $urandom_range(0, 2) == 0) begin
                    act[p] = 1'b1; pwr[p] = 1'($urandom_range(0, 1));
                    paddr[p] = 25'($urandom); pwd[p] = $urandom; pdw[p] = 2'($urandom_range(0, 2));
                end
                drive_port(p, act[p], pwr[p], paddr[p], pwd[p], pdw[p]);
            end
            // Controller: arbitrary ready inside the guard window, then low d cycles, then data.
            if (in_flight && e_cyc >= 0 && cyc > e_cyc) begin
                if (cyc <= e_cyc + G1) bus1.sdram_ready = 1'($urandom_range(0, 1));
                else if (cyc <= e_cyc + G1 + d) bus1.sdram_ready = 1'b0;
                else bus1.sdram_ready = 1'b1;
                bus1.sdram_rdata = (cyc > e_cyc + G1 + d) ? ret : $urandom;
            end else begin
                bus1.sdram_ready = ($urandom_range(0, 3) != 0);
                bus1.sdram_rdata = $urandom;
            end
            // Arbitration outcome for requests the idle arbiter samples this cycle.
            if (!in_flight && cyc >= idle_from && (act[0] || act[1])) begin
                if (act[0] && act[1]) win = RR ? !last : 1'b0;
                else win = act[1];
                last = win; in_flight = 1'b1; exp_en = cyc + 1; e_cyc = -1;
            end
        end
        chk("rnd_progress", 128'(n_txn > 100), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
